// File: rtl/l2_pkg.sv
// Shared definitions for the L2 stream-buffer fill path.
// Holds the stream/line/beat geometry, the FSM state type, the packing of an L2
// write address {sid, wr_ptr, beat} and the extraction of the URAM channel from
// that address. The channel is the top channels_width bits of the address.
package l2_pkg;

  localparam int nstrms         = 32'd64;
  localparam int nstrms_width   = $clog2(nstrms);
  localparam int channels_width = 32'd2;
  localparam int l2_ncl         = 32'd128;
  localparam int l2_ncl_width   = $clog2(l2_ncl);
  localparam int DATA_WIDTH     = 32'd64;
  localparam int WAYS           = 32'd8;
  localparam int beat_bits      = WAYS * DATA_WIDTH;
  localparam int beats          = 32'd2;
  localparam int beat_width     = $clog2(beats);
  localparam int wa_width       = nstrms_width + l2_ncl_width + beat_width;

  typedef logic [nstrms_width-1:0]   sid_t;
  typedef logic [l2_ncl_width-1:0]   ptr_t;
  typedef logic [beat_width-1:0]     beat_idx_t;
  typedef logic [wa_width-1:0]       wa_t;
  typedef logic [channels_width-1:0] chan_t;

  localparam beat_idx_t beat_one  = beat_idx_t'(1'b1);
  localparam beat_idx_t last_beat = beat_idx_t'(beats - 32'd1);
  localparam ptr_t      ptr_one   = ptr_t'(1'b1);

  // IDLE: waiting for beat 0 of a line; FILL: some beats of the line written.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

  // L2 write address as seen by the URAM bank: stream, line slot, beat in line.
  function automatic wa_t pack_wa(input sid_t sid, input ptr_t ptr, input beat_idx_t beat);
    return {sid, ptr, beat};
  endfunction

  // URAM channel selected by a write address (upper stream-id bits).
  function automatic chan_t wa_channel(input wa_t wa);
    return wa[wa_width-1 -: channels_width];
  endfunction

endpackage

// File: rtl/l2_wr_ptr_tbl.sv
// Per-stream L2 write-pointer table.
// One pointer per stream, each counting lines written into that stream's L2 area
// and wrapping naturally at l2_ncl (power of two).
// Ports:
//   clk1x, reset      clock and synchronous active-high reset (all pointers -> 0)
//   clr_v, clr_sid    clear the pointer of clr_sid
//   inc_v, inc_sid    advance the pointer of inc_sid by one line
//   rd_sid, rd_ptr    combinational read port
// A clear and an increment never target the same stream in one cycle: clears are
// only taken while the fill FSM is idle, increments only on a line's last beat.
module l2_wr_ptr_tbl
  import l2_pkg::*;
(
  input  logic                     clk1x,
  input  logic                     reset,
  input  logic                     clr_v,
  input  logic [nstrms_width-1:0]  clr_sid,
  input  logic                     inc_v,
  input  logic [nstrms_width-1:0]  inc_sid,
  input  logic [nstrms_width-1:0]  rd_sid,
  output logic [l2_ncl_width-1:0]  rd_ptr
);

  logic [l2_ncl_width-1:0] ptr_r [nstrms];

  // Pointer storage: reset, clear and increment ports.
  always_ff @(posedge clk1x) begin
    if (reset) begin
      for (int i = 0; i < nstrms; i++) begin
        ptr_r[i] <= '0;
      end
    end else begin
      if (clr_v) begin
        ptr_r[clr_sid] <= '0;
      end
      if (inc_v) begin
        ptr_r[inc_sid] <= ptr_r[inc_sid] + ptr_one;
      end
    end
  end

  assign rd_ptr = ptr_r[rd_sid];

endmodule

// File: rtl/l2_fill_wr_ctrl.sv
// Upstream fill stage of the L2 stream buffer.
// Accepts host read-data beats, writes them into the L2 URAMs through the
// registered we/wa/wd interface and, once a whole cache line has been written,
// hands the stream id of that line to l2_ctrl_top through a one-entry response slot.
// Ports:
//   clk1x, reset                      clock, synchronous active-high reset
//   i_rst_v/i_rst_r/i_rst_sid         clear one stream's write pointer
//   i_d_v/i_d_r/i_d_sid/i_d_d         host data beats (beats per line, contiguous)
//   o_we/o_wa/o_wd                    L2 write port, one cycle after a beat accept
//   o_rsp_v/o_rsp_r/o_rsp_sid         line-complete response
//   o_err                             sticky: a later beat carried a different sid
module l2_fill_wr_ctrl
  import l2_pkg::*;
(
  input  logic                     clk1x,
  input  logic                     reset,
  input  logic                     i_rst_v,
  output logic                     i_rst_r,
  input  logic [nstrms_width-1:0]  i_rst_sid,
  input  logic                     i_d_v,
  output logic                     i_d_r,
  input  logic [nstrms_width-1:0]  i_d_sid,
  input  logic [beat_bits-1:0]     i_d_d,
  output logic                     o_we,
  output logic [wa_width-1:0]      o_wa,
  output logic [beat_bits-1:0]     o_wd,
  output logic                     o_rsp_v,
  input  logic                     o_rsp_r,
  output logic [nstrms_width-1:0]  o_rsp_sid,
  output logic                     o_err
);

  fill_state_e state_r;
  beat_idx_t   beat_cnt_r;
  sid_t        line_sid_r;
  logic        rsp_pend_r;
  sid_t        rsp_pend_sid_r;

  logic        idle_s;
  logic        last_pend_s;
  logic        slot_full_s;
  logic        rst_rdy_s;
  logic        d_rdy_s;
  logic        d_acc_s;
  logic        rst_acc_s;
  logic        last_acc_s;
  sid_t        addr_sid_s;
  ptr_t        rd_ptr_s;

  // Handshake decode and address-stream selection.
  always_comb begin
    idle_s      = (state_r == ST_IDLE);
    last_pend_s = (state_r == ST_FILL) && (beat_cnt_r == last_beat);
    // The response occupies the slot from the last-beat accept (delay stage)
    // until it is taken at o_rsp_v & o_rsp_r.
    slot_full_s = rsp_pend_r | o_rsp_v;
    rst_rdy_s   = ~reset & idle_s;
    // Pointer reset beats a beat-0 in the same idle cycle; only a last beat
    // can be held off by an undelivered response.
    d_rdy_s     = ~reset & ~(idle_s & i_rst_v) & ~(last_pend_s & slot_full_s & ~o_rsp_r);
    d_acc_s     = i_d_v & d_rdy_s;
    rst_acc_s   = i_rst_v & rst_rdy_s;
    last_acc_s  = d_acc_s & last_pend_s;
    // Beat 0 addresses with its own sid; later beats reuse the captured line sid.
    if (idle_s) begin
      addr_sid_s = i_d_sid;
    end else begin
      addr_sid_s = line_sid_r;
    end
  end

  assign i_d_r   = d_rdy_s;
  assign i_rst_r = rst_rdy_s;

  l2_wr_ptr_tbl u_ptr_tbl (
    .clk1x   (clk1x),
    .reset   (reset),
    .clr_v   (rst_acc_s),
    .clr_sid (i_rst_sid),
    .inc_v   (last_acc_s),
    .inc_sid (line_sid_r),
    .rd_sid  (addr_sid_s),
    .rd_ptr  (rd_ptr_s)
  );

  // Fill FSM, L2 write register, error flag and response slot.
  always_ff @(posedge clk1x) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      beat_cnt_r     <= '0;
      line_sid_r     <= '0;
      o_we           <= 1'b0;
      o_wa           <= '0;
      o_wd           <= '0;
      o_err          <= 1'b0;
      rsp_pend_r     <= 1'b0;
      rsp_pend_sid_r <= '0;
      o_rsp_v        <= 1'b0;
      o_rsp_sid      <= '0;
    end else begin
      o_we <= d_acc_s;
      if (d_acc_s) begin
        o_wa <= pack_wa(addr_sid_s, rd_ptr_s, beat_cnt_r);
        o_wd <= i_d_d;
      end

      case (state_r)
        ST_IDLE: begin
          if (d_acc_s) begin
            line_sid_r <= i_d_sid;
            beat_cnt_r <= beat_one;
            state_r    <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (d_acc_s) begin
            if (i_d_sid != line_sid_r) begin
              o_err <= 1'b1;
            end
            if (last_pend_s) begin
              beat_cnt_r <= '0;
              state_r    <= ST_IDLE;
            end else begin
              beat_cnt_r <= beat_cnt_r + beat_one;
            end
          end
        end
        default: begin
          beat_cnt_r <= '0;
          state_r    <= ST_IDLE;
        end
      endcase

      // One-cycle delay so the response trails the line's final L2 write.
      rsp_pend_r <= last_acc_s;
      if (last_acc_s) begin
        rsp_pend_sid_r <= line_sid_r;
      end

      if (rsp_pend_r) begin
        o_rsp_v   <= 1'b1;
        o_rsp_sid <= rsp_pend_sid_r;
      end else if (o_rsp_v && o_rsp_r) begin
        o_rsp_v <= 1'b0;
      end
    end
  end

endmodule
